// File: rtl/mat_vect_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mat_vect_seq_ctrl
//   Job sequencer for the mat_vect_mult datapath. One job is accepted per
//   start handshake. For each job it streams the N column indices (pulsing
//   init with the first one), idles for the vector_mult pipeline latency,
//   captures the row sums into the datapath output chain, then shifts them
//   out one per cycle, each tagged with its row index.
//
// Parameters
//   N       vector length / number of matrix rows (>= 1)
//   VV_LAT  cycles from the last element issued to vv_oup valid (>= 0)
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        job request, accepted when i_start & o_start_ready
//   o_start_ready  high only while idle
//   i_abort        cancel the current job, back to idle next cycle
//   o_elem_idx     column index k of the operands fetched this cycle
//   o_elem_valid   operands valid this cycle
//   o_init         restart the datapath accumulators (with k == 0)
//   o_shift_en     1 = shift the output chain, 0 = load it from vv_oup
//   o_out_valid    datapath result for row o_out_row is present
//   o_out_row      row index of the current result
//   o_busy         inverse of o_start_ready
//   o_done         one-cycle pulse with the last o_out_valid of a job
// -----------------------------------------------------------------------------
module mat_vect_seq_ctrl #(
   parameter  int N      = 3,
   parameter  int VV_LAT = 1,
   localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   output logic          o_start_ready,
   input  logic          i_abort,
   output logic [IW-1:0] o_elem_idx,
   output logic          o_elem_valid,
   output logic          o_init,
   output logic          o_shift_en,
   output logic          o_out_valid,
   output logic [IW-1:0] o_out_row,
   output logic          o_busy,
   output logic          o_done
);

   // One counter serves the element, drain and shift phases, so it is sized
   // for the longest of them.
   localparam int CNT_MAX = (N > VV_LAT) ? N : VV_LAT;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] LAST_N     = CW'(N - 1);
   localparam logic [CW-1:0] LAST_DRAIN = (VV_LAT > 0) ? CW'(VV_LAT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_CAPTURE,
      S_SHIFT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_last_n;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its inputs, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign w_last_n = (r_cnt == LAST_N);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      o_start_ready = 1'b0;
      o_elem_idx    = '0;
      o_elem_valid  = 1'b0;
      o_init        = 1'b0;
      o_shift_en    = 1'b0;
      o_out_valid   = 1'b0;
      o_out_row     = '0;
      o_done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            o_start_ready = 1'b1;
            if (i_start) begin
               w_state_nxt = S_ACCUM;
               w_cnt_nxt   = '0;
            end
         end

         S_ACCUM: begin
            o_elem_valid = 1'b1;
            o_elem_idx   = r_cnt[IW-1:0];
            o_init       = (r_cnt == '0);
            if (w_last_n) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (VV_LAT == 0) ? S_CAPTURE : S_DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         S_DRAIN: begin
            if (r_cnt == LAST_DRAIN) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_CAPTURE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         // shift_en stays low here: the chain loads all row sums at this edge.
         S_CAPTURE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SHIFT;
         end

         // The last row needs no further shift; leaving shift_en low lets the
         // chain reload harmlessly since the accumulators are holding. For
         // N == 1 the first cycle is also the last, so shift_en never rises.
         S_SHIFT: begin
            o_out_valid = 1'b1;
            o_out_row   = r_cnt[IW-1:0];
            o_shift_en  = ~w_last_n;
            o_done      = w_last_n;
            if (w_last_n) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort overrides the normal transition; an aborted job never reports done.
      if (i_abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         o_done      = 1'b0;
      end
   end

   assign o_busy = ~o_start_ready;

endmodule

// File: tb/tb_mat_vect_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mat_vect_seq_ctrl
//   Directed bench for mat_vect_seq_ctrl. Instance u_dut1 runs N=3, VV_LAT=1
//   driving a behavioural mat_vect_mult model; u_dut2 runs N=1, VV_LAT=0.
//   Stimulus pushes the expected result stream (cycle, row, value, done) into
//   per-instance queues; monitors pop and compare on every out_valid.
// -----------------------------------------------------------------------------
module tb_mat_vect_seq_ctrl;

   localparam int N1   = 3;
   localparam int LAT1 = 1;
   localparam int IW1  = 2;
   localparam int N2   = 1;
   localparam int LAT2 = 0;
   localparam int IW2  = 1;

   logic clk = 1'b0;
   logic rst;
   logic abort;
   logic start1;
   logic start2;

   always #5 clk = ~clk;

   // u_dut1 signals
   logic           sr1, ev1, init1, sh1, ov1, busy1, done1;
   logic [IW1-1:0] idx1, row1;
   // u_dut2 signals
   logic           sr2, ev2, init2, sh2, ov2, busy2, done2;
   logic [IW2-1:0] idx2, row2;

   mat_vect_seq_ctrl #(.N(N1), .VV_LAT(LAT1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .o_start_ready(sr1),
      .i_abort(abort), .o_elem_idx(idx1), .o_elem_valid(ev1), .o_init(init1),
      .o_shift_en(sh1), .o_out_valid(ov1), .o_out_row(row1), .o_busy(busy1),
      .o_done(done1)
   );

   mat_vect_seq_ctrl #(.N(N2), .VV_LAT(LAT2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start2), .o_start_ready(sr2),
      .i_abort(abort), .o_elem_idx(idx2), .o_elem_valid(ev2), .o_init(init2),
      .o_shift_en(sh2), .o_out_valid(ov2), .o_out_row(row2), .o_busy(busy2),
      .o_done(done2)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- behavioural datapath models ----------------
   int a_m [3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
   int b_v [3];
   int acc1 [3];
   int pipe1 [3];   // one stage of vector_mult latency
   int chain1 [3];

   always @(posedge clk) begin
      for (int r = 0; r < N1; r++) begin
         int prod;
         prod = 0;
         if (ev1 === 1'b1 && idx1 < 3) prod = a_m[r][idx1] * b_v[idx1];
         acc1[r]  <= (init1 === 1'b1) ? prod : acc1[r] + prod;
         pipe1[r] <= acc1[r];
         if (sh1 !== 1'b1)   chain1[r] <= pipe1[r];
         else if (r < N1-1)  chain1[r] <= chain1[r+1];
         else                chain1[r] <= 0;
      end
   end

   int acc2;
   int chain2;
   always @(posedge clk) begin
      int prod;
      prod = (ev2 === 1'b1) ? 5 * 7 : 0;
      acc2 <= (init2 === 1'b1) ? prod : acc2 + prod;
      if (sh2 !== 1'b1) chain2 <= acc2;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int cyc;
      int row;
      int val;
      bit done;
   } exp_t;

   exp_t q1 [$];
   exp_t q2 [$];

   task automatic push1(input int t, input int v0, input int v1, input int v2,
                        input int nrows, input bit with_done);
      int v [3];
      v = '{v0, v1, v2};
      for (int r = 0; r < nrows; r++) begin
         exp_t e;
         e.cyc  = t + N1 + LAT1 + 2 + r;
         e.row  = r;
         e.val  = v[r];
         e.done = with_done && (r == N1 - 1);
         q1.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (ov1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1 unexpected out_valid: row %0d value %0d (cycle %0d)", row1, chain1[0], cyc);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("dut1 out cycle", cyc, e.cyc);
            check("dut1 out_row", row1, e.row);
            check("dut1 result", chain1[0], e.val);
            check("dut1 done", done1, e.done);
         end
      end else if (done1 !== 1'b0) begin
         check("dut1 done without out_valid", done1, 0);
      end
   end

   bit saw_sh2 = 1'b0;
   always @(negedge clk) begin
      if (sh2 === 1'b1) saw_sh2 = 1'b1;
      if (ov2 === 1'b1) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut2 unexpected out_valid: value %0d (cycle %0d)", chain2, cyc);
         end else begin
            exp_t e;
            e = q2.pop_front();
            check("dut2 out cycle", cyc, e.cyc);
            check("dut2 out_row", row2, e.row);
            check("dut2 result", chain2, e.val);
            check("dut2 done", done2, e.done);
         end
      end else if (done2 !== 1'b0) begin
         check("dut2 done without out_valid", done2, 0);
      end
   end

   // Advance n clock edges and step 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      rst    = 1'b1;
      abort  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      b_v    = '{1, 1, 2};
      tick(3);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst start_ready1", sr1, 1);
      check("rst busy1", busy1, 0);
      check("rst elem_valid1", ev1, 0);
      check("rst elem_idx1", idx1, 0);
      check("rst init1", init1, 0);
      check("rst shift_en1", sh1, 0);
      check("rst out_valid1", ov1, 0);
      check("rst out_row1", row1, 0);
      check("rst done1", done1, 0);
      check("rst start_ready2", sr2, 1);
      check("rst busy2", busy2, 0);

      // Scenarios 1-3: start held high; job 1 b=[1,1,2], job 2 b=[0,0,0]
      tick(1);
      start1 = 1'b1;
      t = cyc;
      push1(t,     9, 21, 33, 3, 1'b1);
      push1(t + 9, 0,  0,  0, 3, 1'b1);
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         check("s1 start_ready", sr1, (c == 0 || c == 9));
         check("s1 busy", busy1, !(c == 0 || c == 9));
         check("s1 elem_valid", ev1, (c >= 1 && c <= 3));
         check("s1 init", init1, (c == 1));
         check("s1 shift_en", sh1, (c == 6 || c == 7));
         if (c >= 1 && c <= 3) check("s1 elem_idx", idx1, c - 1);
         if (c == 5) b_v = '{0, 0, 0};
         tick(1);
      end
      start1 = 1'b0;
      @(negedge clk);
      check("s2 second init", init1, 1);
      check("s2 second elem_idx", idx1, 0);
      tick(9);

      // Scenario 4: abort during DRAIN, then abort+start together in IDLE
      b_v    = '{1, 1, 2};
      start1 = 1'b1;
      t = cyc;
      tick(1);
      start1 = 1'b0;
      tick(3);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      @(negedge clk);
      check("s4 idle after abort", sr1, 1);
      check("s4 no out_valid", ov1, 0);
      check("s4 no done", done1, 0);
      tick(1);
      start1 = 1'b1;
      abort  = 1'b1;
      t = cyc;
      push1(t, 9, 21, 33, 3, 1'b1);
      tick(1);
      start1 = 1'b0;
      abort  = 1'b0;
      @(negedge clk);
      check("s4 accepted despite abort", init1, 1);
      tick(10);

      // Scenario 5: reset at T+7 mid-SHIFT
      start1 = 1'b1;
      t = cyc;
      push1(t, 9, 21, 33, 2, 1'b0);
      tick(1);
      start1 = 1'b0;
      tick(6);
      rst = 1'b1;
      tick(1);
      @(negedge clk);
      check("s5 start_ready", sr1, 1);
      check("s5 busy", busy1, 0);
      check("s5 out_valid", ov1, 0);
      check("s5 out_row", row1, 0);
      check("s5 shift_en", sh1, 0);
      check("s5 done", done1, 0);
      check("s5 elem_valid", ev1, 0);
      tick(1);
      rst = 1'b0;
      tick(3);

      // Scenario 6: N=1, VV_LAT=0, a=5, b=7
      start2 = 1'b1;
      t = cyc;
      begin
         exp_t e;
         e.cyc  = t + 3;
         e.row  = 0;
         e.val  = 35;
         e.done = 1'b1;
         q2.push_back(e);
      end
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         check("s6 start_ready", sr2, (c == 0 || c == 4));
         check("s6 init", init2, (c == 1));
         check("s6 elem_valid", ev2, (c == 1));
         if (c == 1) check("s6 elem_idx", idx2, 0);
         tick(1);
         start2 = 1'b0;
      end
      tick(3);

      check("dut1 pending outputs", q1.size(), 0);
      check("dut2 pending outputs", q2.size(), 0);
      check("dut2 shift_en ever high", saw_sh2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
